// File: rtl/audio_adc_i2s_rx_if.sv
// ---------------------------------------------------------------------------
// audio_adc_i2s_rx_if
// Parallel-side bundle between the I2S ADC receiver and the CPU PIOs.
//
// Signals:
//   rd_ack     : single-clk pulse from the CPU, consumes the held pair
//   left_data  : last complete left sample (two's complement)
//   right_data : last complete right sample (two's complement)
//   adc_rdy    : level, high while an unacknowledged pair is held
//   overrun    : sticky, a pair was overwritten before it was acknowledged
//
// Modports:
//   master : CPU / PIO side (drives rd_ack, reads the sample words)
//   slave  : receiver side (drives the sample words and flags)
// ---------------------------------------------------------------------------
interface audio_adc_i2s_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  adc_rdy;
  logic                  overrun;

  modport master (
    output rd_ack,
    input  left_data,
    input  right_data,
    input  adc_rdy,
    input  overrun
  );

  modport slave (
    input  rd_ack,
    output left_data,
    output right_data,
    output adc_rdy,
    output overrun
  );
endinterface

// File: rtl/audio_adc_i2s_rx.sv
// ---------------------------------------------------------------------------
// audio_adc_i2s_rx
// Deserializes the codec I2S ADC stream into parallel stereo words in the
// clk domain and presents them with a ready level and sticky overrun flag.
//
// Parameters:
//   DATA_WIDTH  : bits captured per channel (16..32), MSB first
//
// Ports:
//   clk         : system clock, at least 8x aud_bclk
//   reset_n     : asynchronous active-low reset
//   aud_bclk    : codec bit clock (asynchronous to clk)
//   aud_adclrck : codec frame clock, low = left, high = right
//   aud_adcdat  : codec serial data
//   bus         : slave side of audio_adc_i2s_rx_if (rd_ack in; left_data,
//                 right_data, adc_rdy, overrun out)
// ---------------------------------------------------------------------------
module audio_adc_i2s_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     aud_bclk,
  input  logic                     aud_adclrck,
  input  logic                     aud_adcdat,
  audio_adc_i2s_rx_if.slave        bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SKIP,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  // Synchronizers. BCLK and data share depth so a sampled bit lines up with
  // the BCLK edge that qualifies it.
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_s3_q;
  logic dat_s1_q,  dat_s2_q;

  state_t                state_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [DATA_WIDTH-1:0] left_hold_q;
  logic                  frame_bad_q;

  logic [DATA_WIDTH-1:0] left_data_q;
  logic [DATA_WIDTH-1:0] right_data_q;
  logic                  adc_rdy_q;
  logic                  overrun_q;

  logic                  bclk_rise;
  logic                  lr_edge;
  logic                  last_bit;
  logic                  in_data;
  logic                  word_done;
  logic                  publish_d;
  logic [DATA_WIDTH-1:0] shift_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_s3_q <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
    end else begin
      bclk_s1_q <= aud_bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lrck_s1_q <= aud_adclrck;
      lrck_s2_q <= lrck_s1_q;
      // LRCK's third stage only advances on a BCLK rise, so it holds the
      // channel currently being received and lr_edge lands on a bit slot.
      if (bclk_rise) begin
        lrck_s3_q <= lrck_s2_q;
      end
      dat_s1_q  <= aud_adcdat;
      dat_s2_q  <= dat_s1_q;
    end
  end

  always_comb begin
    bclk_rise = bclk_s2_q & ~bclk_s3_q;
    lr_edge   = bclk_rise & (lrck_s2_q ^ lrck_s3_q);
    shift_d   = {shift_q, dat_s2_q};
    last_bit  = (bit_cnt_q == CW'(DATA_WIDTH - 1));
    in_data   = (state_q == ST_SKIP) || (state_q == ST_SHIFT);
    word_done = bclk_rise & ~lr_edge & in_data & last_bit;
    // lrck_s3_q is the channel of the word just completed (no edge this rise).
    publish_d = word_done & lrck_s3_q & ~frame_bad_q;
  end

  // Framing FSM. The BCLK rise that reveals an LRCK change is the skipped
  // slot of I2S alignment; ST_SKIP is the landing state after it, so the
  // next rise (the second after the transition) captures the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      frame_bad_q <= 1'b0;
    end else if (bclk_rise) begin
      case (state_q)
        ST_HUNT: begin
          // Only a falling LRCK (start of left) starts capture, so any
          // right channel seen before the first left is dropped.
          if (lr_edge && !lrck_s2_q) begin
            state_q   <= ST_SKIP;
            bit_cnt_q <= '0;
          end
        end
        ST_SKIP, ST_SHIFT: begin
          if (lr_edge) begin
            // Channel ended early: drop the partial word and poison the pair.
            frame_bad_q <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= ST_SKIP;
          end else begin
            shift_q   <= shift_d[DATA_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + CW'(1);
            state_q   <= ST_SHIFT;
            if (last_bit) begin
              state_q <= ST_WAIT;
              if (!lrck_s3_q) begin
                left_hold_q <= shift_d;
                frame_bad_q <= 1'b0;
              end
            end
          end
        end
        ST_WAIT: begin
          if (lr_edge) begin
            state_q   <= ST_SKIP;
            bit_cnt_q <= '0;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  // Output holding registers and ready/overrun handshake. A publish wins
  // over a coincident ack; overrun records a publish onto an unacked pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_data_q  <= '0;
      right_data_q <= '0;
      adc_rdy_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (publish_d) begin
      left_data_q  <= left_hold_q;
      right_data_q <= shift_d;
      adc_rdy_q    <= 1'b1;
      overrun_q    <= adc_rdy_q & ~bus.rd_ack;
    end else if (bus.rd_ack) begin
      adc_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.left_data  = left_data_q;
  assign bus.right_data = right_data_q;
  assign bus.adc_rdy    = adc_rdy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_audio_adc_i2s_rx
// Directed bench for audio_adc_i2s_rx: clk = 50 MHz, BCLK = clk/16 (close to
// 3.072 MHz), 64 BCLK per frame, I2S alignment, DATA_WIDTH = 16.
// ---------------------------------------------------------------------------
module tb_audio_adc_i2s_rx;

  localparam int DW = 16;

  logic clk         = 1'b0;
  logic reset_n     = 1'b0;
  logic aud_bclk    = 1'b0;
  logic aud_adclrck = 1'b0;
  logic aud_adcdat  = 1'b0;

  audio_adc_i2s_rx_if #(.DATA_WIDTH(DW)) bus ();

  audio_adc_i2s_rx #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (aud_adcdat),
    .bus         (bus)
  );

  always #10 clk = ~clk;

  int   n_vec    = 0;
  int   n_miss   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   lsb_cyc  = 0;
  int   base;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts adc_rdy rising edges as a downstream edge-capture PIO would.
  always @(negedge clk) begin
    rdy_prev <= bus.adc_rdy;
    if (bus.adc_rdy && !rdy_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One BCLK slot: LRCK/data change with the falling edge, 8 clk low, 8 high.
  // ack_mode 1: rd_ack pulse early in the low half.
  // ack_mode 2: rd_ack high on the clk edge that samples this slot.
  task automatic send_bit(input logic lr, input logic d, input int ack_mode, input bit mark_lsb);
    @(negedge clk);
    aud_bclk    = 1'b0;
    aud_adclrck = lr;
    aud_adcdat  = d;
    if (ack_mode == 1) begin
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      repeat (7) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    aud_bclk = 1'b1;
    if (mark_lsb) lsb_cyc = cyc;
    if (ack_mode == 2) begin
      repeat (2) @(negedge clk);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (7) @(negedge clk);
    end
  endtask

  function automatic logic slot_bit(input logic [DW-1:0] word, input int s, input int nbits);
    if (s >= 1 && s <= nbits) return word[DW-s];
    return 1'b0;
  endfunction

  task automatic send_chan(input logic lr, input logic [DW-1:0] word, input int nbits,
                           input int nslots, input int ack_slot, input int ack_mode);
    for (int s = 0; s < nslots; s++) begin
      send_bit(lr, slot_bit(word, s, nbits), (s == ack_slot) ? ack_mode : 0,
               (lr == 1'b1) && (s == DW));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int ack_slot, input int ack_mode);
    send_chan(1'b0, l, DW, 32, ack_slot, ack_mode);
    send_chan(1'b1, r, DW, 32, ack_slot - 32, ack_mode);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    check_val({tag, "_ack_rdy"}, 32'(bus.adc_rdy), 32'd0);
    check_val({tag, "_ack_ovr"}, 32'(bus.overrun), 32'd0);
  endtask

  logic [DW-1:0] hs_l [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [DW-1:0] hs_r [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

  initial begin
    bus.rd_ack = 1'b0;
    reset_n    = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_left",  32'(bus.left_data),  32'h0);
    check_val("rst_right", 32'(bus.right_data), 32'h0);
    check_val("rst_rdy",   32'(bus.adc_rdy),    32'd0);
    check_val("rst_ovr",   32'(bus.overrun),    32'd0);
    reset_n = 1'b1;

    // Right-channel preamble so the first left start is visible.
    send_chan(1'b1, 16'h0000, DW, 32, -1, 0);

    // Nominal capture.
    send_frame(16'h8001, 16'h7FFE, -1, 0);
    check_val("nom_latency", 32'(rise_cyc - lsb_cyc), 32'd3);
    check_val("nom_left",    32'(bus.left_data),  32'h8001);
    check_val("nom_right",   32'(bus.right_data), 32'h7FFE);
    check_val("nom_rdy",     32'(bus.adc_rdy),    32'd1);
    check_val("nom_ovr",     32'(bus.overrun),    32'd0);
    do_ack("nom");

    // Handshake: each pair acked in the middle of the following frame.
    base = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(hs_l[i], hs_r[i], 10, 1);
      check_val($sformatf("hs%0d_left", i),  32'(bus.left_data),  32'(hs_l[i]));
      check_val($sformatf("hs%0d_right", i), 32'(bus.right_data), 32'(hs_r[i]));
      check_val($sformatf("hs%0d_ovr", i),   32'(bus.overrun),    32'd0);
    end
    do_ack("hs");
    check_val("hs_rises", 32'(rise_cnt - base), 32'd4);

    // No ack across two frames.
    send_frame(16'h1111, 16'h2222, -1, 0);
    send_frame(16'h3333, 16'h4444, -1, 0);
    check_val("ovr_left",  32'(bus.left_data),  32'h3333);
    check_val("ovr_right", 32'(bus.right_data), 32'h4444);
    check_val("ovr_rdy",   32'(bus.adc_rdy),    32'd1);
    check_val("ovr_ovr",   32'(bus.overrun),    32'd1);
    do_ack("ovr");

    // Short left channel: LRCK toggles after 10 bits.
    base = rise_cnt;
    send_chan(1'b0, 16'hBEEF, 10, 11, -1, 0);
    send_chan(1'b1, 16'hCCCC, DW, 32, -1, 0);
    check_val("short_rises", 32'(rise_cnt - base), 32'd0);
    check_val("short_rdy",   32'(bus.adc_rdy),    32'd0);
    check_val("short_left",  32'(bus.left_data),  32'h3333);
    check_val("short_right", 32'(bus.right_data), 32'h4444);
    send_frame(16'hAAAA, 16'h5555, -1, 0);
    check_val("recov_left",  32'(bus.left_data),  32'hAAAA);
    check_val("recov_right", 32'(bus.right_data), 32'h5555);
    check_val("recov_rdy",   32'(bus.adc_rdy),    32'd1);
    do_ack("recov");

    // Publish and ack on the same clk edge.
    send_frame(16'h1234, 16'h5678, -1, 0);
    check_val("sim_pre_rdy", 32'(bus.adc_rdy), 32'd1);
    send_frame(16'h9ABC, 16'hDEF0, 48, 2);
    check_val("sim_rdy",   32'(bus.adc_rdy),    32'd1);
    check_val("sim_ovr",   32'(bus.overrun),    32'd0);
    check_val("sim_left",  32'(bus.left_data),  32'h9ABC);
    check_val("sim_right", 32'(bus.right_data), 32'hDEF0);

    // Reset in the middle of a left channel's shift.
    send_chan(1'b0, 16'hFFFF, DW, 9, -1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("midrst_left",  32'(bus.left_data),  32'h0);
    check_val("midrst_right", 32'(bus.right_data), 32'h0);
    check_val("midrst_rdy",   32'(bus.adc_rdy),    32'd0);
    check_val("midrst_ovr",   32'(bus.overrun),    32'd0);

    // Release reset partway through a right channel; it must be ignored.
    for (int s = 0; s < 32; s++) begin
      if (s == 6) reset_n = 1'b1;
      send_bit(1'b1, slot_bit(16'h7777, s, DW), 0, s == DW);
    end
    check_val("rel_rdy",   32'(bus.adc_rdy),    32'd0);
    check_val("rel_right", 32'(bus.right_data), 32'h0);
    base = rise_cnt;
    send_frame(16'h0F0F, 16'hF0F0, -1, 0);
    check_val("rel_rises", 32'(rise_cnt - base), 32'd1);
    check_val("rel_left",  32'(bus.left_data),  32'h0F0F);
    check_val("rel_right2", 32'(bus.right_data), 32'hF0F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
